branch_resolve_ctrl: RTL

//   Multi-cycle branch resolution controller for the RV32I core.
//   - Accepts one B-type instruction plus its PC over a valid/ready handshake.
//   - Sequences a register-file read of rs1/rs2, evaluates the branch condition, computes the next PC.
//   - Presents a redirect to the fetch stage and holds it until acknowledged.
//   - Keeps branch and taken-branch statistics counters.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/b_type_instruction.sv | 19 +
 rtl/branch_resolve_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants, state encoding and legality helper for branch resolution
package branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CMP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // funct3 010/011 are the only reserved encodings in the branch opcode space
    function automatic logic is_legal_branch(input logic [6:0] opc, input logic [2:0] f3);
        return (opc == OPC_BRANCH) && (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/b_type_instruction.sv
// rtl/b_type_instruction.sv - field extraction and sign-extended immediate for B-type words
module b_type_instruction #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm
);

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm    = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - multi-cycle branch resolver: rf read, compare, next-PC redirect, stats
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  pc,
    output logic             rf_rd_en,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    output logic             redirect_valid,
    input  logic             redirect_ack,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             taken,
    output logic             illegal,
    output logic             misaligned,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken
);

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              instr_ready_q, instr_ready_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic              misaligned_q, misaligned_d;
    logic [CNT_W-1:0]  stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0]  stat_taken_q, stat_taken_d;

    logic [6:0]        dec_opcode;
    logic [2:0]        dec_funct3;
    logic [XLEN-1:0]   dec_imm;
    logic              cond;
    logic [XLEN-1:0]   target;

    b_type_instruction #(.XLEN(XLEN)) u_dec (
        .instr  (instr_q),
        .opcode (dec_opcode),
        .funct3 (dec_funct3),
        .rs1    (rf_rs1_addr),
        .rs2    (rf_rs2_addr),
        .imm    (dec_imm)
    );

    always_comb begin
        cond = 1'b0;
        case (dec_funct3)
            F3_BEQ:  cond = (rf_rs1_data == rf_rs2_data);
            F3_BNE:  cond = (rf_rs1_data != rf_rs2_data);
            F3_BLT:  cond = ($signed(rf_rs1_data) <  $signed(rf_rs2_data));
            F3_BGE:  cond = ($signed(rf_rs1_data) >= $signed(rf_rs2_data));
            F3_BLTU: cond = (rf_rs1_data <  rf_rs2_data);
            F3_BGEU: cond = (rf_rs1_data >= rf_rs2_data);
            default: cond = 1'b0;
        endcase
        // opcode was already vetted at accept; gating on it keeps a stale word from ever redirecting
        if (dec_opcode != OPC_BRANCH) begin
            cond = 1'b0;
        end
        target = cond ? (pc_q + dec_imm) : (pc_q + XLEN'(4));
    end

    always_comb begin
        state_d          = state_q;
        instr_d          = instr_q;
        pc_d             = pc_q;
        redirect_pc_d    = redirect_pc_q;
        instr_ready_d    = instr_ready_q;
        rf_rd_en_d       = 1'b0;
        redirect_valid_d = redirect_valid_q;
        taken_d          = taken_q;
        illegal_d        = illegal_q;
        misaligned_d     = misaligned_q;
        stat_branches_d  = stat_branches_q;
        stat_taken_d     = stat_taken_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d       = instruction;
                    pc_d          = pc;
                    instr_ready_d = 1'b0;
                    taken_d       = 1'b0;
                    misaligned_d  = 1'b0;
                    if (is_legal_branch(instruction[6:0], instruction[14:12])) begin
                        illegal_d  = 1'b0;
                        rf_rd_en_d = 1'b1;
                        state_d    = S_READ;
                    end else begin
                        illegal_d        = 1'b1;
                        redirect_pc_d    = pc + XLEN'(4);
                        redirect_valid_d = 1'b1;
                        state_d          = S_RESP;
                    end
                end
            end
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                taken_d          = cond;
                redirect_pc_d    = target;
                misaligned_d     = cond && target[1];
                redirect_valid_d = 1'b1;
                state_d          = S_RESP;
            end
            S_RESP: begin
                if (redirect_ack) begin
                    redirect_valid_d = 1'b0;
                    instr_ready_d    = 1'b1;
                    state_d          = S_IDLE;
                    if (!illegal_q) begin
                        stat_branches_d = stat_branches_q + CNT_W'(1);
                        stat_taken_d    = stat_taken_q + CNT_W'(taken_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            instr_q          <= '0;
            pc_q             <= '0;
            redirect_pc_q    <= '0;
            instr_ready_q    <= 1'b1;
            rf_rd_en_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            taken_q          <= 1'b0;
            illegal_q        <= 1'b0;
            misaligned_q     <= 1'b0;
            stat_branches_q  <= '0;
            stat_taken_q     <= '0;
        end else begin
            state_q          <= state_d;
            instr_q          <= instr_d;
            pc_q             <= pc_d;
            redirect_pc_q    <= redirect_pc_d;
            instr_ready_q    <= instr_ready_d;
            rf_rd_en_q       <= rf_rd_en_d;
            redirect_valid_q <= redirect_valid_d;
            taken_q          <= taken_d;
            illegal_q        <= illegal_d;
            misaligned_q     <= misaligned_d;
            stat_branches_q  <= stat_branches_d;
            stat_taken_q     <= stat_taken_d;
        end
    end

    assign instr_ready    = instr_ready_q;
    assign rf_rd_en       = rf_rd_en_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign taken          = taken_q;
    assign illegal        = illegal_q;
    assign misaligned     = misaligned_q;
    assign stat_branches  = stat_branches_q;
    assign stat_taken     = stat_taken_q;

endmodule
